// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the CNN layer sequencer and its helpers.
package cnn_seq_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 16;

    // Ping-pong feature-map bank indices
    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Clearable saturating up-counter; expired_o marks the LIMIT-th counted cycle.
module seq_watchdog #(
    parameter int LIMIT = 1048576
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Count while enabled, hold at LIMIT, clear on request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = inc_i && (cnt_q >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Steps layer engines through en/fin handshakes over a ping-pong buffer.
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int NUM_LAYERS  = 2,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int GAP_CYCLES  = 8,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         host_we,
    input  logic [ADDR_W-1:0]            host_addr,
    input  logic [DATA_W-1:0]            host_din,
    input  logic                         load_done,
    output logic [NUM_LAYERS-1:0]        layer_en,
    input  logic [NUM_LAYERS-1:0]        layer_fin,
    input  logic [NUM_LAYERS-1:0]        layer_wr_en,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_wr_addr,
    input  logic [NUM_LAYERS*DATA_W-1:0] layer_wr_data,
    output logic                         bank0_we,
    output logic [ADDR_W-1:0]            bank0_addr,
    output logic [DATA_W-1:0]            bank0_din,
    output logic                         bank1_we,
    output logic [ADDR_W-1:0]            bank1_addr,
    output logic [DATA_W-1:0]            bank1_din,
    output logic                         rd_bank_sel,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         err_timeout,
    output logic                         err_wr_drop
);

    localparam int LIDX_W = $clog2(NUM_LAYERS) + 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    seq_state_e              state_q, state_d;
    logic [LIDX_W-1:0]       idx_q, idx_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    fin_prev_q, fin_prev_d;
    logic [NUM_LAYERS-1:0]   en_q, en_d;
    logic                    b0_we_q, b0_we_d, b1_we_q, b1_we_d;
    logic [ADDR_W-1:0]       b0_addr_q, b0_addr_d, b1_addr_q, b1_addr_d;
    logic [DATA_W-1:0]       b0_din_q, b0_din_d, b1_din_q, b1_din_d;
    logic                    rd_sel_q, rd_sel_d, busy_q, busy_d, done_q, done_d;
    logic                    err_to_q, err_to_d, err_drop_q, err_drop_d;

    logic                    act_fin, act_we, wd_expired, wr_bank;
    logic [ADDR_W-1:0]       act_addr;
    logic [DATA_W-1:0]       act_data;

    seq_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wd (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q != ST_RUN),
        .inc_i     (state_q == ST_RUN),
        .expired_o (wd_expired)
    );

    // Pick out the active engine's fin and write port
    always_comb begin
        act_fin  = 1'b0;
        act_we   = 1'b0;
        act_addr = '0;
        act_data = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (idx_q == LIDX_W'(i)) begin
                act_fin  = layer_fin[i];
                act_we   = layer_wr_en[i];
                act_addr = layer_wr_addr[i*ADDR_W +: ADDR_W];
                act_data = layer_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Odd layers read bank 1 and so write bank 0, and vice versa
    assign wr_bank = idx_q[0] ? BANK0 : BANK1;

    // Next-state, bank-write routing and registered output decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        // Outside RUN the previous-fin is forced high, so a fin already
        // high on RUN entry needs a fresh rising edge to count.
        fin_prev_d = (state_q == ST_RUN) ? act_fin : 1'b1;
        err_to_d   = err_to_q;
        err_drop_d = err_drop_q;
        b0_we_d    = 1'b0;
        b0_addr_d  = b0_addr_q;
        b0_din_d   = b0_din_q;
        b1_we_d    = 1'b0;
        b1_addr_d  = b1_addr_q;
        b1_din_d   = b1_din_q;

        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            gap_d   = '0;
        end else begin
            if (host_we && (state_q != ST_LOAD)) err_drop_d = 1'b1;
            case (state_q)
                ST_IDLE: if (start) begin
                    state_d    = ST_LOAD;
                    err_to_d   = 1'b0;
                    err_drop_d = host_we;
                end
                ST_LOAD: begin
                    if (host_we) begin
                        b0_we_d   = 1'b1;
                        b0_addr_d = host_addr;
                        b0_din_d  = host_din;
                    end
                    if (load_done) begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (act_we) begin
                        if (wr_bank == BANK1) begin
                            b1_we_d   = 1'b1;
                            b1_addr_d = act_addr;
                            b1_din_d  = act_data;
                        end else begin
                            b0_we_d   = 1'b1;
                            b0_addr_d = act_addr;
                            b0_din_d  = act_data;
                        end
                    end
                    if (act_fin && !fin_prev_q) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end else if (wd_expired) begin
                        state_d  = ST_ERR;
                        err_to_d = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        gap_d = '0;
                        if (idx_q == LIDX_W'(NUM_LAYERS - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_RUN;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
                default: ;
            endcase
        end

        for (int i = 0; i < NUM_LAYERS; i++) begin
            en_d[i] = (state_d == ST_RUN) && (idx_d == LIDX_W'(i));
        end
        rd_sel_d = (state_d == ST_RUN) && idx_d[0];
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            gap_q      <= '0;
            fin_prev_q <= 1'b1;
            en_q       <= '0;
            b0_we_q    <= 1'b0;
            b0_addr_q  <= '0;
            b0_din_q   <= '0;
            b1_we_q    <= 1'b0;
            b1_addr_q  <= '0;
            b1_din_q   <= '0;
            rd_sel_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_to_q   <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            fin_prev_q <= fin_prev_d;
            en_q       <= en_d;
            b0_we_q    <= b0_we_d;
            b0_addr_q  <= b0_addr_d;
            b0_din_q   <= b0_din_d;
            b1_we_q    <= b1_we_d;
            b1_addr_q  <= b1_addr_d;
            b1_din_q   <= b1_din_d;
            rd_sel_q   <= rd_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_to_q   <= err_to_d;
            err_drop_q <= err_drop_d;
        end
    end

    assign layer_en    = en_q;
    assign bank0_we    = b0_we_q;
    assign bank0_addr  = b0_addr_q;
    assign bank0_din   = b0_din_q;
    assign bank1_we    = b1_we_q;
    assign bank1_addr  = b1_addr_q;
    assign bank1_din   = b1_din_q;
    assign rd_bank_sel = rd_sel_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign err_timeout = err_to_q;
    assign err_wr_drop = err_drop_q;

endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
- Sequences the CNN layer engines (C1S2, C3S4, ...) through their en/work_finished handshake, one layer at a time.
- Owns a two-bank ping-pong feature-map buffer (16-bit x 6K per bank): accepts host image loading into bank 0, then routes each active layer's single write port into the opposite bank from the one it reads.
- Provides a per-layer watchdog and a clean abort path.
- Sits between the top-level host/loader and the layer engines.

Parameters:
- NUM_LAYERS, 2, number of chained layer engines (1..8).
- ADDR_W, 32, buffer address width.
- DATA_W, 16, buffer data width.
- GAP_CYCLES, 8, idle cycles with en low between layers, so an engine resets its internal counters.
- TIMEOUT_CYC, 1048576, maximum cycles a layer may stay in RUN before an error is flagged.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame (IDLE only).
- abort  in  1  synchronous abort, any state.
- host_we  in  1  host write strobe.
- host_addr  in  ADDR_W  host write address.
- host_din  in  DATA_W  host write data.
- load_done  in  1  one-cycle pulse; host finished loading.
- layer_en  out  NUM_LAYERS  one-hot engine enable.
- layer_fin  in  NUM_LAYERS  engine work_finished (level).
- layer_wr_en  in  NUM_LAYERS  engine write strobes.
- layer_wr_addr  in  NUM_LAYERS*ADDR_W  packed engine write addresses.
- layer_wr_data  in  NUM_LAYERS*DATA_W  packed engine write data.
- bank0_we / bank1_we  out  1  bank write enables.
- bank0_addr / bank1_addr  out  ADDR_W  bank write addresses.
- bank0_din / bank1_din  out  DATA_W  bank write data.
- rd_bank_sel  out  1  bank the active layer reads (0/1).
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.
- err_timeout  out  1  sticky watchdog error.
- err_wr_drop  out  1  sticky flag: host write outside LOAD.

Behaviour:
- Reset: every output 0. State IDLE, layer_idx 0, counters 0.
- States are IDLE, LOAD, RUN, GAP, DONE, ERR.
- IDLE: start moves to LOAD and clears both error flags. Host writes in IDLE are dropped and set err_wr_drop.
- LOAD:
  - host_we/addr/din are registered onto bank0 with 1-cycle latency.
  - load_done moves to RUN with layer_idx=0. A host_we in the same cycle as load_done is still written.
- RUN:
  - layer_en[layer_idx]=1 (registered; asserts the cycle after entering RUN).
  - rd_bank_sel = layer_idx[0].
  - The active engine's write is forwarded, 1-cycle registered, to bank (layer_idx+1)%2. Writes from inactive engines are ignored. Host writes are dropped and set err_wr_drop.
  - Rising edge of layer_fin[layer_idx] (registered edge detect) moves to GAP. A write in the fin cycle is still forwarded.
  - A fin level already high on RUN entry is ignored until it falls and rises again.
- GAP:
  - layer_en all 0 and no bank writes.
  - Counts GAP_CYCLES cycles. Then, if layer_idx==NUM_LAYERS-1, go to DONE; otherwise layer_idx++ and go to RUN.
- DONE: frame_done=1 for exactly one cycle, then IDLE. Final result sits in bank NUM_LAYERS%2.
- Watchdog:
  - Counter clears on RUN entry and increments each RUN cycle.
  - Reaching TIMEOUT_CYC moves to ERR: err_timeout=1, all en 0.
  - ERR is left only by abort or reset.
- abort: in any state, next cycle is IDLE. layer_en=0, bank writes squashed, layer_idx=0, error flags keep their values. abort wins over start, load_done and fin in the same cycle.
- start outside IDLE is ignored.
- Reset mid-frame: asynchronous return to the reset values, no further writes.
- Width rules:
  - layer_idx is $clog2(NUM_LAYERS)+1 bits wide.
  - The gap counter is $clog2(GAP_CYCLES+1) bits wide.
  - The watchdog counter is $clog2(TIMEOUT_CYC+1) bits wide and saturates.

Decomposition:
- Shared package cnn_seq_pkg holds:
  - the state enum (IDLE, LOAD, RUN, GAP, DONE, ERR);
  - the default widths ADDR_W and DATA_W;
  - the bank index constants.
- One sub-module, seq_watchdog: a clearable, saturating up-counter with a terminal flag, reused by other layer controllers.
- The write-port muxing stays inline.

Test Plan (NUM_LAYERS=2, GAP_CYCLES=4, TIMEOUT_CYC=64):
- Load: start, then 6144 host writes with addr i, data i+10000, then load_done -> bank0 sees the same writes one cycle later, bank1_we never asserts, state reaches RUN and layer_en=2'b01.
- Engine 0 writes addr 5, data 0x1234, then raises fin -> bank1 gets the write, layer_en=0 for 4 cycles, then layer_en=2'b10 and rd_bank_sel=1.
- Engine 1 writes addr 7, data 0xBEEF, then raises fin -> bank0 gets the write, frame_done pulses exactly once 4+1 cycles after fin, then busy=0.
- Engine 0 never raises fin -> after 64 RUN cycles err_timeout=1 and layer_en=0; abort returns to IDLE with err_timeout still 1; the next start clears it.
- host_we while in RUN -> no bank write and err_wr_drop=1. Asserting rst_n=0 mid-RUN -> all outputs 0 asynchronously.
- abort and fin in the same cycle -> IDLE and no GAP. start in the same cycle as abort while in IDLE -> stays IDLE.
